// File: rtl/bcd_countdown_16bit.sv
// 4-digit packed-BCD countdown timer with stop-at-zero or wrap-to-max.
// All outputs registered; one-cycle latency per event.
module bcd_countdown_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] bcd_load,
  input  logic [15:0] bcd_max,
  input  logic        start,
  input  logic        pause,
  input  logic        tick,
  input  logic        wrap_en,
  output logic [15:0] bcd_out,
  output logic        running,
  output logic        done,
  output logic        zero_pulse,
  output logic        borrow,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] dec_val;
  logic        zp_nx, br_nx, le_nx;
  logic        cnt_zero;

  function automatic logic bcd_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple borrow: a 0 digit becomes 9 and passes the borrow upward.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign cnt_zero = (cnt == 16'h0000);
  assign dec_val  = bcd_dec(cnt);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    zp_nx    = 1'b0;
    br_nx    = 1'b0;
    le_nx    = 1'b0;
    if (load) begin
      if (bcd_ok(bcd_load)) begin
        cnt_nx   = bcd_load;
        state_nx = IDLE;
      end else begin
        le_nx = 1'b1;
      end
    end else if (pause) begin
      if (state == RUN) state_nx = PAUSED;
    end else if (start) begin
      if ((state == IDLE || state == PAUSED) &&
          (!cnt_zero || wrap_en))
        state_nx = RUN;
    end else if (tick && state == RUN) begin
      if (!cnt_zero) begin
        cnt_nx = dec_val;
        if (dec_val == 16'h0000) begin
          zp_nx = 1'b1;
          if (!wrap_en) state_nx = DONE;
        end
      end else if (wrap_en) begin
        cnt_nx = bcd_ok(bcd_max) ? bcd_max : 16'h9999;
        br_nx  = 1'b1;
      end else begin
        state_nx = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 16'h0000;
      zero_pulse <= 1'b0;
      borrow     <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      zero_pulse <= zp_nx;
      borrow     <= br_nx;
      load_err   <= le_nx;
    end
  end

  assign bcd_out = cnt;
  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule
